// File: rtl/cic_array_pkg.sv
// Shared state type and datapath widths for the CIC decimator array controller.
package cic_array_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_e;

   localparam int CIC_DW = 32;
   localparam int RATE_W = 16;
   localparam int COMB_W = 3;
   localparam int DISC_W = 5;

endpackage

// File: rtl/cic_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after the pointer.
module cic_rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   idx_o,
   output logic              any_o
);

   logic [CH_W:0] cand;

   // Walk the channels starting at the pointer, wrapping at NUM_CH rather than 2**CH_W.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = {1'b0, ptr_i} + (CH_W+1)'(k);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!any_o && req_i[cand[CH_W-1:0]]) begin
            any_o                   = 1'b1;
            gnt_o[cand[CH_W-1:0]]   = 1'b1;
            idx_o                   = cand[CH_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cic_array_ctrl.sv
// CIC array controller: shared config, reset/settle sequencing and sample arbitration.
// Optional m_frame counter enabled by defining CIC_ARRAY_FRAME_EN.
module cic_array_ctrl
   import cic_array_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int RST_CYCLES = 4,
   parameter int DISCARD    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   input  logic [RATE_W-1:0]        cfg_rate,
   input  logic [COMB_W-1:0]        cfg_comb,
   output logic                     cfg_ready,
   output logic                     cic_rst,
   output logic [RATE_W-1:0]        cic_dec_num,
   output logic [COMB_W-1:0]        cic_comb_num,
   input  logic [NUM_CH*CIC_DW-1:0] cic_out,
   input  logic [NUM_CH-1:0]        cic_rdy,
   output logic [CIC_DW-1:0]        m_data,
   output logic [CH_W-1:0]          m_chan,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [NUM_CH-1:0]        overrun,
   output logic                     busy
`ifdef CIC_ARRAY_FRAME_EN
   ,
   output logic [15:0]              m_frame
`endif
);

   localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [DISC_W-1:0] DISC_LIM = DISC_W'(DISCARD);
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

   state_e state_q, state_d;

   logic [RCNT_W-1:0] rstCnt_q, rstCnt_d;
   logic [DISC_W-1:0] discCnt_q [NUM_CH];
   logic [DISC_W-1:0] discCnt_d [NUM_CH];
   logic [CIC_DW-1:0] slotData_q [NUM_CH];
   logic [CIC_DW-1:0] slotData_d [NUM_CH];
   logic [NUM_CH-1:0] slotFull_q, slotFull_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [CIC_DW-1:0] mData_q, mData_d;
   logic [CH_W-1:0]   mChan_q, mChan_d;
   logic              mValid_q, mValid_d;
   logic [NUM_CH-1:0] overrun_q, overrun_d;
   logic [RATE_W-1:0] decNum_q, decNum_d;
   logic [COMB_W-1:0] combNum_q, combNum_d;
`ifdef CIC_ARRAY_FRAME_EN
   logic [15:0]       frameCnt_q, frameCnt_d;
   logic [15:0]       mFrame_q, mFrame_d;
`endif

   logic              cfgAccept;
   logic              settleDone;
   logic              loadEn;
   logic              fire;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gntIdx;
   logic              gntAny;

   cic_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .req_i (slotFull_q),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gntIdx),
      .any_o (gntAny)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // cfg_ready is masked by rst so nothing is accepted while reset is asserted.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      cic_rst   = 1'b0;
      busy      = 1'b1;
      case (state_q)
         IDLE: begin
            cfg_ready = !rst;
            cic_rst   = 1'b1;
            if (cfg_valid) state_d = FLUSH;
         end
         FLUSH: begin
            cic_rst = 1'b1;
            if (rstCnt_q == '0) state_d = SETTLE;
         end
         SETTLE: begin
            if (settleDone) state_d = RUN;
         end
         RUN: begin
            cfg_ready = !rst;
            busy      = 1'b0;
            if (cfg_valid) state_d = FLUSH;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cfgAccept = cfg_valid && cfg_ready;
   assign loadEn    = !mValid_q || m_ready;
   assign fire      = mValid_q && m_ready;

   // A slot granted this cycle counts as free, so a same-cycle strobe refills it without loss.
   always_comb begin
      rstCnt_d   = rstCnt_q;
      discCnt_d  = discCnt_q;
      slotData_d = slotData_q;
      slotFull_d = slotFull_q;
      ptr_d      = ptr_q;
      mData_d    = mData_q;
      mChan_d    = mChan_q;
      mValid_d   = mValid_q;
      overrun_d  = overrun_q;
      decNum_d   = decNum_q;
      combNum_d  = combNum_q;
      settleDone = 1'b1;
`ifdef CIC_ARRAY_FRAME_EN
      frameCnt_d = frameCnt_q;
      mFrame_d   = mFrame_q;
`endif

      if (state_q == FLUSH && rstCnt_q != '0) begin
         rstCnt_d = rstCnt_q - RCNT_W'(1);
      end

      if (state_q == SETTLE) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cic_rdy[i] && discCnt_q[i] < DISC_LIM) begin
               discCnt_d[i] = discCnt_q[i] + DISC_W'(1);
            end
            if (discCnt_d[i] < DISC_LIM) settleDone = 1'b0;
         end
      end

      if (state_q == RUN) begin
`ifdef CIC_ARRAY_FRAME_EN
         if (fire && mChan_q == LAST_CH) frameCnt_d = frameCnt_q + 16'd1;
`endif
         if (loadEn) begin
            if (gntAny) begin
               mValid_d             = 1'b1;
               mData_d              = slotData_q[gntIdx];
               mChan_d              = gntIdx;
               slotFull_d[gntIdx]   = 1'b0;
               ptr_d                = (gntIdx == LAST_CH) ? '0 : gntIdx + CH_W'(1);
`ifdef CIC_ARRAY_FRAME_EN
               mFrame_d             = frameCnt_d;
`endif
            end else begin
               mValid_d = 1'b0;
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (cic_rdy[i]) begin
               if (!slotFull_q[i] || (loadEn && gnt[i])) begin
                  slotData_d[i] = cic_out[i*CIC_DW +: CIC_DW];
                  slotFull_d[i] = 1'b1;
               end else begin
                  overrun_d[i] = 1'b1;
               end
            end
         end
      end

      // Accepting a configuration starts a clean flush: pending output is abandoned.
      if (cfgAccept) begin
         decNum_d   = cfg_rate;
         combNum_d  = cfg_comb;
         rstCnt_d   = RCNT_W'(RST_CYCLES - 1);
         slotFull_d = '0;
         mValid_d   = 1'b0;
         overrun_d  = '0;
         for (int i = 0; i < NUM_CH; i++) discCnt_d[i] = '0;
`ifdef CIC_ARRAY_FRAME_EN
         frameCnt_d = '0;
         mFrame_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstCnt_q   <= '0;
         slotFull_q <= '0;
         ptr_q      <= '0;
         mData_q    <= '0;
         mChan_q    <= '0;
         mValid_q   <= 1'b0;
         overrun_q  <= '0;
         decNum_q   <= '0;
         combNum_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            discCnt_q[i]  <= '0;
            slotData_q[i] <= '0;
         end
`ifdef CIC_ARRAY_FRAME_EN
         frameCnt_q <= '0;
         mFrame_q   <= '0;
`endif
      end else begin
         rstCnt_q   <= rstCnt_d;
         discCnt_q  <= discCnt_d;
         slotData_q <= slotData_d;
         slotFull_q <= slotFull_d;
         ptr_q      <= ptr_d;
         mData_q    <= mData_d;
         mChan_q    <= mChan_d;
         mValid_q   <= mValid_d;
         overrun_q  <= overrun_d;
         decNum_q   <= decNum_d;
         combNum_q  <= combNum_d;
`ifdef CIC_ARRAY_FRAME_EN
         frameCnt_q <= frameCnt_d;
         mFrame_q   <= mFrame_d;
`endif
      end
   end

   assign cic_dec_num  = decNum_q;
   assign cic_comb_num = combNum_q;
   assign m_data       = mData_q;
   assign m_chan       = mChan_q;
   assign m_valid      = mValid_q;
   assign overrun      = overrun_q;
`ifdef CIC_ARRAY_FRAME_EN
   assign m_frame      = mFrame_q;
`endif

endmodule

// File: tb/tb_cic_array_ctrl.sv
// Randomised scoreboard bench for cic_array_ctrl against a behavioural model.
module tb_cic_array_ctrl;

   localparam int NUM_CH     = 4;
   localparam int CH_W       = 2;
   localparam int RST_CYCLES = 4;
   localparam int DISCARD    = 2;

   localparam int M_IDLE   = 0;
   localparam int M_FLUSH  = 1;
   localparam int M_SETTLE = 2;
   localparam int M_RUN    = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   cfg_valid = 1'b0;
   logic [15:0]            cfg_rate = '0;
   logic [2:0]             cfg_comb = '0;
   logic                   cfg_ready;
   logic                   cic_rst;
   logic [15:0]            cic_dec_num;
   logic [2:0]             cic_comb_num;
   logic [NUM_CH*32-1:0]   cic_out = '0;
   logic [NUM_CH-1:0]      cic_rdy = '0;
   logic [31:0]            m_data;
   logic [CH_W-1:0]        m_chan;
   logic                   m_valid;
   logic                   m_ready = 1'b0;
   logic [NUM_CH-1:0]      overrun;
   logic                   busy;
`ifdef CIC_ARRAY_FRAME_EN
   logic [15:0]            m_frame;
`endif

   always #5 clk = ~clk;

   cic_array_ctrl #(
      .NUM_CH     (NUM_CH),
      .CH_W       (CH_W),
      .RST_CYCLES (RST_CYCLES),
      .DISCARD    (DISCARD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_rate     (cfg_rate),
      .cfg_comb     (cfg_comb),
      .cfg_ready    (cfg_ready),
      .cic_rst      (cic_rst),
      .cic_dec_num  (cic_dec_num),
      .cic_comb_num (cic_comb_num),
      .cic_out      (cic_out),
      .cic_rdy      (cic_rdy),
      .m_data       (m_data),
      .m_chan       (m_chan),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .overrun      (overrun),
      .busy         (busy)
`ifdef CIC_ARRAY_FRAME_EN
      ,
      .m_frame      (m_frame)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          chan;
      logic [15:0] frame;
   } beat_t;

   beat_t expQ[$];
   int    checks = 0;
   int    errors = 0;
   bit    checking = 1'b0;

   // Behavioural model of the controller, advanced once per clock edge.
   int                mMode = M_IDLE;
   int                mFlushLeft = 0;
   int                mPtr = 0;
   int                mSeen [NUM_CH];
   bit                mSlotFull [NUM_CH];
   logic [31:0]       mSlotData [NUM_CH];
   bit                mValid = 1'b0;
   logic [31:0]       mData = '0;
   int                mChan = 0;
   logic [15:0]       mFrame = '0;
   logic [15:0]       mFrameCnt = '0;
   logic [NUM_CH-1:0] mOverrun = '0;
   logic [15:0]       mRate = '0;
   logic [2:0]        mComb = '0;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelStep();
      bit hs;
      bit allSeen;
      int win;
      int j;
      if (rst) begin
         mMode = M_IDLE; mFlushLeft = 0; mPtr = 0; mValid = 1'b0; mData = '0; mChan = 0;
         mFrame = '0; mFrameCnt = '0; mOverrun = '0; mRate = '0; mComb = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            mSeen[i] = 0; mSlotFull[i] = 1'b0; mSlotData[i] = '0;
         end
         return;
      end
      hs = cfg_valid && (mMode == M_IDLE || mMode == M_RUN);
      case (mMode)
         M_FLUSH: begin
            mFlushLeft--;
            if (mFlushLeft == 0) begin
               mMode = M_SETTLE;
               for (int i = 0; i < NUM_CH; i++) mSeen[i] = 0;
            end
         end
         M_SETTLE: begin
            allSeen = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               if (cic_rdy[i] && mSeen[i] < DISCARD) mSeen[i]++;
               if (mSeen[i] < DISCARD) allSeen = 1'b0;
            end
            if (allSeen) mMode = M_RUN;
         end
         M_RUN: begin
            if (!mValid || m_ready) begin
               if (mValid && m_ready && mChan == NUM_CH-1) mFrameCnt++;
               win = -1;
               for (int k = 0; k < NUM_CH; k++) begin
                  j = (mPtr + k) % NUM_CH;
                  if (win < 0 && mSlotFull[j]) win = j;
               end
               if (win >= 0) begin
                  mValid = 1'b1; mData = mSlotData[win]; mChan = win; mFrame = mFrameCnt;
                  mSlotFull[win] = 1'b0;
                  mPtr = (win + 1) % NUM_CH;
               end else begin
                  mValid = 1'b0;
               end
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (cic_rdy[i]) begin
                  if (mSlotFull[i]) mOverrun[i] = 1'b1;
                  else begin
                     mSlotFull[i] = 1'b1;
                     mSlotData[i] = cic_out[i*32 +: 32];
                  end
               end
            end
         end
         default: ;
      endcase
      if (hs) begin
         mRate = cfg_rate; mComb = cfg_comb; mMode = M_FLUSH; mFlushLeft = RST_CYCLES;
         mValid = 1'b0; mOverrun = '0; mFrameCnt = '0; mFrame = '0;
         for (int i = 0; i < NUM_CH; i++) mSlotFull[i] = 1'b0;
      end
   endtask

   // Advance the model over the edge just taken, then drive the next cycle's inputs.
   task automatic applyStimulus(input bit r, input bit cv, input logic [15:0] rate,
                                input logic [2:0] comb, input logic [NUM_CH-1:0] rdy,
                                input logic [NUM_CH*32-1:0] outs, input bit mr);
      beat_t b;
      @(posedge clk);
      #1;
      modelStep();
      checking  = 1'b1;
      rst       = r;
      cfg_valid = cv;
      cfg_rate  = rate;
      cfg_comb  = comb;
      cic_rdy   = rdy;
      cic_out   = outs;
      m_ready   = mr;
      if (mValid && mr) begin
         b.data = mData; b.chan = mChan; b.frame = mFrame;
         expQ.push_back(b);
      end
   endtask

   task automatic idle(input int n, input bit mr);
      repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, mr);
   endtask

   task automatic strobe(input int ch, input logic [31:0] val, input bit mr);
      logic [NUM_CH*32-1:0] outs;
      logic [NUM_CH-1:0]    rdy;
      outs = '0;
      rdy  = '0;
      outs[ch*32 +: 32] = val;
      rdy[ch] = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, rdy, outs, mr);
   endtask

   task automatic settleAndRun();
      logic [NUM_CH*32-1:0] outs;
      idle(RST_CYCLES + 1, 1'b1);
      repeat (DISCARD) begin
         for (int i = 0; i < NUM_CH; i++) outs[i*32 +: 32] = $urandom;
         applyStimulus(1'b0, 1'b0, '0, '0, {NUM_CH{1'b1}}, outs, 1'b1);
      end
      idle(2, 1'b1);
   endtask

   function automatic logic [NUM_CH-1:0] randRdy(input int pct);
      logic [NUM_CH-1:0] r;
      for (int i = 0; i < NUM_CH; i++) r[i] = ($urandom_range(0, 99) < pct);
      return r;
   endfunction

   always @(negedge clk) begin
      beat_t b;
      if (checking) begin
         checkOutput("busy", busy, (mMode != M_RUN));
         checkOutput("cfg_ready", cfg_ready, (!rst && (mMode == M_IDLE || mMode == M_RUN)));
         checkOutput("cic_rst", cic_rst, (mMode == M_IDLE || mMode == M_FLUSH));
         checkOutput("cic_dec_num", cic_dec_num, mRate);
         checkOutput("cic_comb_num", cic_comb_num, mComb);
         checkOutput("m_valid", m_valid, mValid);
         checkOutput("m_data", m_data, mData);
         checkOutput("m_chan", m_chan, mChan);
         checkOutput("overrun", overrun, mOverrun);
`ifdef CIC_ARRAY_FRAME_EN
         checkOutput("m_frame", m_frame, mFrame);
`endif
         if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL beat_unexpected: got chan %0d data 0x%0h, expected no beat", m_chan, m_data);
            end else begin
               b = expQ.pop_front();
               checkOutput("beat_data", m_data, b.data);
               checkOutput("beat_chan", m_chan, b.chan);
`ifdef CIC_ARRAY_FRAME_EN
               checkOutput("beat_frame", m_frame, b.frame);
`endif
            end
         end
      end
   end

   initial begin
      logic [NUM_CH*32-1:0] outs;
      bit r;
      bit cv;

      repeat (3) applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'd3, 3'd4, '0, '0, 1'b1);
      settleAndRun();

      repeat (3) begin
         applyStimulus(1'b0, 1'b0, '0, '0, {NUM_CH{1'b1}},
                       {32'h40, 32'h30, 32'h20, 32'h10}, 1'b1);
         idle(1, 1'b1);
      end
      idle(4, 1'b1);

      strobe(1, 32'h111, 1'b0);
      idle(2, 1'b0);
      strobe(1, 32'h222, 1'b0);
      idle(2, 1'b0);
      strobe(1, 32'h333, 1'b0);
      idle(2, 1'b0);
      idle(4, 1'b1);

      strobe(0, 32'hA0, 1'b0);
      idle(1, 1'b0);
      strobe(2, 32'hB2, 1'b0);
      idle(1, 1'b0);
      strobe(2, 32'hC2, 1'b1);
      idle(4, 1'b1);

      strobe(3, 32'hD3, 1'b0);
      idle(1, 1'b0);
      strobe(1, 32'hE1, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'd7, 3'd2, '0, '0, 1'b0);
      settleAndRun();

      for (int n = 0; n < 2000; n++) begin
         r  = (n == 1000 || n == 1001);
         cv = (n == 1002) || ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NUM_CH; i++) outs[i*32 +: 32] = $urandom;
         applyStimulus(r, cv, 16'($urandom), 3'($urandom), randRdy(25), outs,
                       ($urandom_range(0, 99) < 70));
      end

      idle(12, 1'b1);
      @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL beats_outstanding: got %0d undelivered, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
